fp16_to_fp8_packer: RTL and testbench
=====================================

Name: fp16_to_fp8_packer

Overview:
Downstream stage of the byte-serial FP16 approximate multiplier. It takes the 16-bit FP16 product as two bytes, low byte first, and reassembles it. It then converts the value to FP8 E4M3 with round-to-nearest-even, saturation and subnormal flush. Each FP8 result and its status flags are presented on a valid/ready output handshake.

Parameters:
SAT_ON_OVF, 1, 1: overflow saturates to ±448 (S,7'h7E); 0: overflow produces NaN (S,7'h7F).
LSB_FIRST, 1, 1: first accepted byte is FP16[7:0]; 0: first accepted byte is FP16[15:8].

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
ena  in  1  global enable; when low, all state is frozen
in_valid  in  1  in_byte is valid
in_byte  in  8  FP16 result byte from the multiplier
in_ready  out  1  byte accepted on a cycle where in_valid & in_ready
out_valid  out  1  out_fp8 and out_flags are valid
out_ready  in  1  consumer accepts the result
out_fp8  out  8  E4M3 result {S, E[3:0], M[2:0]}, bias 7, no infinities
out_flags  out  3  {nan, ovf, uf}, registered with out_fp8

Behaviour:
- Reset values: out_valid=0, out_fp8=0, out_flags=0, in_ready=0. FSM returns to GET0 and the assembly register is cleared.
- Reset mid-operation discards any partial byte pair or pending result.
- FSM states: GET0, GET1, CONV, HOLD.
- in_ready = ena & (state==GET0 | state==GET1).
- GET0: on accept, store byte into the half selected by LSB_FIRST; go to GET1.
- GET1: on accept, store the other half; go to CONV.
- CONV: one cycle. Compute, register out_fp8/out_flags, set out_valid=1; go to HOLD.
- HOLD: out_valid held high and data stable until out_valid & out_ready. On that edge clear out_valid and go to GET0.
- No skid buffer: no input byte is accepted in CONV or HOLD.
- Latency: second byte accepted at edge N; out_valid=1 after edge N+1. If out_ready=1, the transfer completes at edge N+2 and the next byte can be accepted at edge N+3.
- ena=0: no state, register or output changes; in_ready reads 0; out_valid keeps its value.
- Conversion. FP16 fields: S=h[15], E=h[14:10], m=h[9:0].
  - E==31 (Inf or NaN): result {S,7'h7F}, nan=1.
  - E==0 (zero or FP16 subnormal): result {S,7'h00}; uf=1 iff m!=0.
  - E<=8 (below E4M3 normal range): flush to {S,7'h00}, uf=1. This applies even if rounding would reach 2^-6; no FP8 subnormals are produced.
  - Otherwise e8=E-8 (4-bit) and mantissa=m[9:7], guard=m[6], sticky=|m[5:0].
  - Round up iff guard & (sticky | m[7]). A mantissa carry out of 3'b111 gives mantissa 000 and e8+1.
  - Overflow if the rounded e8>15, or e8==15 with mantissa==111. On overflow ovf=1 and the result is per SAT_ON_OVF.
  - Otherwise result {S,e8[3:0],mantissa} with all flags 0.
- The sign is always preserved, including for zero, NaN and saturated results.
- Each flag describes only the current result; flags are not sticky.

Test Plan:
- Bytes 0x00 then 0x3C (1.0) -> out_fp8=0x38, flags=000. Bytes 0x00,0xBE (-1.5) -> 0xBC, flags=000.
- Rounding, tie-to-even: 0x3C40 -> 0x38. Tie rounds up on odd LSB: 0x3CC0 -> 0x3A. Mantissa carry: 0x3FF0 -> 0x40.
- Range limits, SAT_ON_OVF=1:
  - 0x5F00 (448) -> 0x7E, flags=000.
  - 0x5F80 (480) -> 0x7E, ovf=1.
  - 0xFBFF -> 0xFE, ovf=1.
  - With SAT_ON_OVF=0: 0x5F80 -> 0x7F, ovf=1.
- Specials:
  - 0x7C00 -> 0x7F, nan=1.
  - 0x2000 -> 0x00, uf=1.
  - 0x8000 -> 0x80, flags=000.
  - 0x0001 -> 0x00, uf=1.
- Backpressure: out_ready low 3 cycles after out_valid -> out_valid and data stable, in_ready=0; out_ready=1 -> transfer, in_ready=1 next cycle.
- Disruption:
  - ena=0 between the two bytes for 2 cycles -> byte pair still assembled correctly.
  - rst_n low after the first byte -> the next pair converts correctly (0x00,0x40 -> 0x40).
  - LSB_FIRST=0 with bytes 0x3C,0x00 -> 0x38.

Source files
------------

// File: rtl/fp16_to_fp8_packer.sv
// Reassembles a byte-serial FP16 product and converts it to FP8 E4M3 (RNE,
// saturating or NaN on overflow, subnormal flush) behind a valid/ready output.
module fp16_to_fp8_packer #(
   parameter bit SAT_ON_OVF = 1'b1,
   parameter bit LSB_FIRST  = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       in_valid,
   input  logic [7:0] in_byte,
   output logic       in_ready,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_fp8,
   output logic [2:0] out_flags
);

   typedef enum logic [1:0] {GET0, GET1, CONV, HOLD} state_t;

   state_t      state;
   logic [15:0] h;
   logic        in_acc;

   // rst_n is folded in so in_ready reads 0 while reset is held
   assign in_ready = rst_n & ena & ((state == GET0) | (state == GET1));
   assign in_acc   = in_valid & in_ready;

   logic       s;
   logic [4:0] e;
   logic [9:0] m;
   logic       rup, ovf_c;
   logic [3:0] mr;
   logic [5:0] e8;
   logic [7:0] cv_fp8;
   logic [2:0] cv_flags;

   assign s = h[15];
   assign e = h[14:10];
   assign m = h[9:0];

   // e8 is 6 bits wide so exponents past the E4M3 range stay visible for overflow
   always_comb begin
      rup      = m[6] & ((|m[5:0]) | m[7]);
      mr       = {1'b0, m[9:7]} + {3'b000, rup};
      e8       = {1'b0, e} - 6'd8 + {5'b00000, mr[3]};
      ovf_c    = (e8 > 6'd15) | ((e8 == 6'd15) & (mr[2:0] == 3'b111));
      cv_fp8   = {s, 7'h00};
      cv_flags = 3'b000;
      if (e == 5'd31) begin
         cv_fp8   = {s, 7'h7F};
         cv_flags = 3'b100;
      end else if (e == 5'd0) begin
         cv_flags = {2'b00, |m};
      end else if (e <= 5'd8) begin
         cv_flags = 3'b001;
      end else if (ovf_c) begin
         cv_fp8   = SAT_ON_OVF ? {s, 7'h7E} : {s, 7'h7F};
         cv_flags = 3'b010;
      end else begin
         cv_fp8   = {s, e8[3:0], mr[2:0]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= GET0;
         h         <= '0;
         out_valid <= 1'b0;
         out_fp8   <= '0;
         out_flags <= '0;
      end else if (ena) begin
         case (state)
            GET0: if (in_acc) begin
               if (LSB_FIRST) h[7:0]  <= in_byte;
               else           h[15:8] <= in_byte;
               state <= GET1;
            end
            GET1: if (in_acc) begin
               if (LSB_FIRST) h[15:8] <= in_byte;
               else           h[7:0]  <= in_byte;
               state <= CONV;
            end
            CONV: begin
               out_fp8   <= cv_fp8;
               out_flags <= cv_flags;
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= GET0;
            end
            default: state <= GET0;
         endcase
      end
   end

endmodule

// File: tb/tb_fp16_to_fp8_packer.sv
// Directed bench: dut 0 uses default parameters, dut 1 has SAT_ON_OVF=0 and LSB_FIRST=0.
module tb_fp16_to_fp8_packer;

   logic       clk = 1'b0;
   logic       rst_n, ena, out_ready;
   logic       vin [2];
   logic [7:0] bin [2];
   logic       ird [2];
   logic       ov  [2];
   logic [7:0] fp  [2];
   logic [2:0] fl  [2];

   logic [10:0] q0[$];
   logic [10:0] q1[$];
   logic [10:0] e0, e1;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fp16_to_fp8_packer #(.SAT_ON_OVF(1'b1), .LSB_FIRST(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(vin[0]), .in_byte(bin[0]),
      .in_ready(ird[0]), .out_valid(ov[0]), .out_ready(out_ready),
      .out_fp8(fp[0]), .out_flags(fl[0]));

   fp16_to_fp8_packer #(.SAT_ON_OVF(1'b0), .LSB_FIRST(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(vin[1]), .in_byte(bin[1]),
      .in_ready(ird[1]), .out_valid(ov[1]), .out_ready(out_ready),
      .out_fp8(fp[1]), .out_flags(fl[1]));

   // Monitors: pop the expected {flags,fp8} whenever a transfer is presented
   always @(negedge clk) begin
      if (rst_n && ena && out_ready && ov[0]) begin
         if (q0.size() == 0) begin
            n_err++;
            $display("FAIL mon0 unexpected result fp8=%h flags=%b", fp[0], fl[0]);
         end else begin
            e0 = q0.pop_front();
            if ({fl[0], fp[0]} !== e0) begin
               n_err++;
               $display("FAIL mon0 got fp8=%h flags=%b want fp8=%h flags=%b",
                        fp[0], fl[0], e0[7:0], e0[10:8]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && ena && out_ready && ov[1]) begin
         if (q1.size() == 0) begin
            n_err++;
            $display("FAIL mon1 unexpected result fp8=%h flags=%b", fp[1], fl[1]);
         end else begin
            e1 = q1.pop_front();
            if ({fl[1], fp[1]} !== e1) begin
               n_err++;
               $display("FAIL mon1 got fp8=%h flags=%b want fp8=%h flags=%b",
                        fp[1], fl[1], e1[7:0], e1[10:8]);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic put_byte(input int k, input logic [7:0] b);
      int n = 0;
      vin[k] = 1'b1;
      bin[k] = b;
      @(negedge clk);
      while (!ird[k] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ird[k]) begin
         n_err++;
         $display("FAIL put_byte%0d in_ready timeout got 0 want 1", k);
      end
      @(posedge clk);
      #1 vin[k] = 1'b0;
   endtask

   task automatic send(input int k, input logic [15:0] h, input logic [7:0] xf,
                       input logic [2:0] xg, input int gap);
      if (k == 0) q0.push_back({xg, xf});
      else        q1.push_back({xg, xf});
      n_vec++;
      put_byte(k, (k == 0) ? h[7:0] : h[15:8]);
      if (gap > 0) begin
         ena = 1'b0;
         repeat (gap) begin
            @(negedge clk);
            chk("ena_low_in_ready", ird[k], 0);
         end
         @(posedge clk);
         #1 ena = 1'b1;
      end
      put_byte(k, (k == 0) ? h[15:8] : h[7:0]);
   endtask

   task automatic drain;
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (q0.size() != 0 || q1.size() != 0) begin
         n_err++;
         $display("FAIL drain pending got %0d want 0", q0.size() + q1.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset;
      chk("rst_out_valid", ov[0], 0);
      chk("rst_out_fp8", fp[0], 0);
      chk("rst_out_flags", fl[0], 0);
      chk("rst_in_ready", ird[0], 0);
      chk("rst_in_ready1", ird[1], 0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; ena = 1'b1; out_ready = 1'b1;
      vin[0] = 1'b0; vin[1] = 1'b0; bin[0] = '0; bin[1] = '0;
      #3 chk_reset();
      @(posedge clk); #1 rst_n = 1'b1;

      send(0, 16'h3C00, 8'h38, 3'b000, 0);
      send(0, 16'hBE00, 8'hBC, 3'b000, 0);
      send(0, 16'h3C40, 8'h38, 3'b000, 0);
      send(0, 16'h3CC0, 8'h3A, 3'b000, 0);
      send(0, 16'h3FF0, 8'h40, 3'b000, 0);
      send(0, 16'h5F00, 8'h7E, 3'b000, 0);
      send(0, 16'h5F80, 8'h7E, 3'b010, 0);
      send(0, 16'hFBFF, 8'hFE, 3'b010, 0);
      send(0, 16'h7C00, 8'h7F, 3'b100, 0);
      send(0, 16'h2000, 8'h00, 3'b001, 0);
      send(0, 16'h8000, 8'h80, 3'b000, 0);
      send(0, 16'h0001, 8'h00, 3'b001, 0);
      send(1, 16'h5F80, 8'h7F, 3'b010, 0);
      send(1, 16'h3C00, 8'h38, 3'b000, 0);
      send(0, 16'hC000, 8'hC0, 3'b000, 2);
      drain();

      // Backpressure: result must stay put while out_ready is low
      out_ready = 1'b0;
      send(0, 16'h3C00, 8'h38, 3'b000, 0);
      n = 0;
      @(negedge clk);
      while (!ov[0] && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("bp_out_valid_rise", ov[0], 1);
      repeat (3) begin
         @(negedge clk);
         chk("bp_out_valid_hold", ov[0], 1);
         chk("bp_fp8_stable", fp[0], 8'h38);
         chk("bp_flags_stable", fl[0], 0);
         chk("bp_in_ready_low", ird[0], 0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_out_valid_clear", ov[0], 0);
      chk("bp_in_ready_back", ird[0], 1);
      drain();

      // Reset after the first byte of a pair discards it
      put_byte(0, 8'h55);
      rst_n = 1'b0;
      #1 chk_reset();
      @(posedge clk); #1 rst_n = 1'b1;
      send(0, 16'h4000, 8'h40, 3'b000, 0);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got running want finished");
      $fatal(1);
   end

endmodule
